wb_reg_slave: RTL
=================

// Module: wb_reg_slave
// PURPOSE
// Wishbone classic slave register front-end. It sits directly downstream of the Wishbone master bus.
// It decodes 4 byte registers (CSR, DPR, CMDR, FSMR), buffers write data in a TX FIFO and hands
// commands to a back-end engine over a valid/ready handshake. Completion is raised on irq_o.
// PARAMETERS
// ADDR_WIDTH      2   Wishbone address width; only adr_i[1:0] decoded
// DATA_WIDTH      8   register/data width
// FIFO_DEPTH      4   TX FIFO entries, power of 2, >=2
// TIMEOUT_CYCLES  1024 BUSY watchdog limit (used only with WB_REG_SLAVE_TIMEOUT_EN)
// PORTS
// clk_i        in   1           single clock, all logic on posedge
// rst_i        in   1           synchronous, active-high reset
// cyc_i        in   1           Wishbone cycle
// stb_i        in   1           Wishbone strobe
// we_i         in   1           1=write, 0=read
// adr_i        in   ADDR_WIDTH  register address
// dat_i        in   DATA_WIDTH  write data
// ack_o        out  1           transfer acknowledge
// dat_o        out  DATA_WIDTH  read data, valid while ack_o=1
// irq_o        out  1           level interrupt
// cmd_valid_o  out  1           command offered to back-end
// cmd_o        out  3           command code
// cmd_ready_i  in   1           back-end accepts command
// done_i       in   1           1-cycle completion pulse from back-end
// status_i     in   2           {nak,arb_lost}, sampled with done_i
// rx_wr_i      in   1           load rx_data_i into read-data register
// rx_data_i    in   DATA_WIDTH  received byte
// tx_pop_i     in   1           pop TX FIFO head
// tx_data_o    out  DATA_WIDTH  TX FIFO head (first-word fall-through)
// tx_empty_o   out  1           TX FIFO empty
// BEHAVIOUR
// - Reset: ack_o=0, dat_o=0, irq_o=0, cmd_valid_o=0, cmd_o=0, tx_data_o=0, tx_empty_o=1.
//   Reset also clears all registers, the FIFO and the FSM. Reset mid-handshake aborts the handshake; no partial effects.
// - Bus: cyc_i&stb_i&!ack_o sampled at posedge N sets ack_o=1 for exactly cycle N+1. The register side effect
//   commits at the same edge. ack_o is then forced low for >=1 cycle, so one access gives exactly one ack.
// - CSR (0): [7]EN [6]IE RW; [4]OVF RO sticky, cleared by any CSR write; other bits read 0.
// - DPR (1): write pushes the TX FIFO. When the FIFO is full, the write is dropped and OVF is set.
//   Read returns the rx byte register.
// - CMDR (2) write: [2:0]=cmd. It is accepted only in IDLE with EN=1. Accept: clear DON/NAK/ARL/ERR and enter ISSUE.
//   Otherwise the command is dropped and ERR is set.
//   CMDR read: {DON,NAK,ARL,ERR,1'b0,cmd[2:0]}. A CMDR read clears irq_o.
// - FSMR (3) read-only: {tx_count[3:0], 2'b0, state[1:0]}. Writes are ignored but still acked.
// - FSM: IDLE -> ISSUE on accepted CMDR write.
//   ISSUE: cmd_valid_o=1, cmd_o held; it drops when cmd_valid_o&cmd_ready_i -> BUSY.
//   BUSY: done_i -> IDLE, DON=1, {NAK,ARL}=status_i.
//   EN cleared in ISSUE/BUSY: -> IDLE, ERR=1.
// - irq_o sets on the transition into IDLE with DON|ERR when IE=1. It holds until a CMDR read or reset.
//   When a CMDR read and a new irq set happen in the same cycle, the set wins.
// - FIFO: count 0..FIFO_DEPTH. When push and pop land together, both occur (also when full); count is unchanged.
//   A pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
// - rx_wr_i loads the rx register in 1 cycle. A DPR read in the same cycle returns the old value.
// CONFIGURATION
// WB_REG_SLAVE_TIMEOUT_EN defined:
//   - A watchdog counts cycles in BUSY.
//   - At count TIMEOUT_CYCLES-1 with no done_i: -> IDLE, ERR=1, DON=0.
//   - done_i arriving on that same cycle wins.
// Undefined: BUSY waits indefinitely and no counter is synthesised.
// STRUCTURE
// - Package wb_reg_pkg holds:
//   - register address localparams CSR/DPR/CMDR/FSMR=0..3;
//   - typedef enum fsm_t {IDLE=0,ISSUE=1,BUSY=2};
//   - CSR/CMDR bit-position constants;
//   - command code localparams.
// - Sub-module wb_reg_fifo: parameterised synchronous FWFT FIFO exposing push/pop/full/empty/count.
// TESTING
// - Reset: all outputs at reset values; FSMR read returns 8'h00; CSR read returns 8'h00.
// - CSR write 8'hC0, then read back 8'hC0. Check ack_o is exactly 1 cycle with stb held 3 cycles.
// - 5 DPR writes of 8'h11..8'h55 with FIFO_DEPTH=4: CSR[4]=1, FSMR tx_count=4, 4 pops yield 11,22,33,44.
// - EN=1,IE=1, CMDR write 3'd1: cmd_valid_o until ready. Then done_i with status 2'b10 -> irq_o=1, CMDR read=8'hC1, irq_o=0.
// - CMDR write while BUSY -> ERR=1, cmd_o unchanged. CSR write 8'h00 during BUSY -> IDLE, ERR=1.
// - Timeout build: no done_i for 1024 cycles -> IDLE with ERR=1. rst_i pulse mid-ISSUE -> cmd_valid_o=0 next cycle.

Source files
------------

// File: rtl/wb_reg_pkg.sv
// Shared definitions for the Wishbone register slave: register map, FSM encoding,
// register bit positions and back-end command codes.
package wb_reg_pkg;

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
    localparam logic [1:0] ADR_FSMR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } fsm_t;

    localparam int CSR_EN  = 7;
    localparam int CSR_IE  = 6;
    localparam int CSR_OVF = 4;

    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_ARL = 5;
    localparam int CMDR_ERR = 4;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_WRITE = 3'd4;

endpackage

// File: rtl/wb_reg_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken
// only when a pop lands on the same cycle. The head reads zero while empty.
module wb_reg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage, wrapping pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone classic register front-end: CSR/DPR/CMDR/FSMR, TX FIFO and command handshake.
// Optional BUSY watchdog is compiled in with `define WB_REG_SLAVE_TIMEOUT_EN.
module wb_reg_slave
    import wb_reg_pkg::*;
#(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  irq_o,
    output logic                  cmd_valid_o,
    output logic [2:0]            cmd_o,
    input  logic                  cmd_ready_i,
    input  logic                  done_i,
    input  logic [1:0]            status_i,
    input  logic                  rx_wr_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  tx_pop_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_empty_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fsm_t                  state_r, next_state_s;
    logic                  ack_r, irq_r, cmd_valid_r, cmd_valid_next_s;
    logic [DATA_WIDTH-1:0] dat_r, rx_r, rd_data_s;
    logic                  en_r, ie_r, ovf_r;
    logic                  don_r, nak_r, arl_r, err_r;
    logic [2:0]            cmd_r;
    logic                  tx_full_s, irq_set_s;
    logic [CW-1:0]         tx_count_s;

    // A request is only taken while ack is low, so each access acks exactly once.
    logic req_s, wr_s, rd_s;
    logic [1:0] reg_adr_s;
    assign req_s     = cyc_i & stb_i & ~ack_r;
    assign wr_s      = req_s & we_i;
    assign rd_s      = req_s & ~we_i;
    assign reg_adr_s = adr_i[1:0];

    logic csr_wr_s, dpr_wr_s, cmdr_wr_s, cmdr_rd_s;
    logic cmd_accept_s, cmd_reject_s, tx_drop_s;
    logic done_ev_s, abort_s, timeout_s;
    assign csr_wr_s     = wr_s & (reg_adr_s == ADR_CSR);
    assign dpr_wr_s     = wr_s & (reg_adr_s == ADR_DPR);
    assign cmdr_wr_s    = wr_s & (reg_adr_s == ADR_CMDR);
    assign cmdr_rd_s    = rd_s & (reg_adr_s == ADR_CMDR);
    assign cmd_accept_s = cmdr_wr_s & (state_r == IDLE) & en_r;
    assign cmd_reject_s = cmdr_wr_s & ~cmd_accept_s;
    assign tx_drop_s    = dpr_wr_s & tx_full_s & ~tx_pop_i;
    assign done_ev_s    = (state_r == BUSY) & done_i;
    assign abort_s      = ((state_r == ISSUE) | (state_r == BUSY)) & ~en_r & ~done_ev_s;

`ifdef WB_REG_SLAVE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wdog_r;

    // BUSY watchdog, restarts every time BUSY is entered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_r <= TW'(0);
        end else if (state_r == BUSY) begin
            wdog_r <= wdog_r + TW'(1);
        end else begin
            wdog_r <= TW'(0);
        end
    end

    assign timeout_s = (state_r == BUSY) & (wdog_r == TW'(TIMEOUT_CYCLES - 1)) & ~done_i;
`else
    assign timeout_s = 1'b0;
`endif

    wb_reg_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (dpr_wr_s),
        .push_data (dat_i),
        .pop       (tx_pop_i),
        .head      (tx_data_o),
        .full      (tx_full_s),
        .empty     (tx_empty_o),
        .count     (tx_count_s)
    );

    // FSM state register with registered handshake valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cmd_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cmd_valid_r <= cmd_valid_next_s;
        end
    end

    // FSM next state; losing EN aborts, but a completion in BUSY takes precedence
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (cmd_accept_s) next_state_s = ISSUE; else next_state_s = IDLE;
            ISSUE:   if (!en_r) next_state_s = IDLE;
                     else if (cmd_ready_i) next_state_s = BUSY;
                     else next_state_s = ISSUE;
            BUSY:    if (done_i || !en_r || timeout_s) next_state_s = IDLE; else next_state_s = BUSY;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: next-cycle valid and interrupt request on return to IDLE
    always_comb begin
        cmd_valid_next_s = (next_state_s == ISSUE);
        if (ie_r && (state_r != IDLE) && (next_state_s == IDLE)) begin
            irq_set_s = 1'b1;
        end else begin
            irq_set_s = 1'b0;
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        case (reg_adr_s)
            ADR_CSR: begin
                rd_data_s[CSR_EN]  = en_r;
                rd_data_s[CSR_IE]  = ie_r;
                rd_data_s[CSR_OVF] = ovf_r;
            end
            ADR_DPR:  rd_data_s = rx_r;
            ADR_CMDR: begin
                rd_data_s[CMDR_DON] = don_r;
                rd_data_s[CMDR_NAK] = nak_r;
                rd_data_s[CMDR_ARL] = arl_r;
                rd_data_s[CMDR_ERR] = err_r;
                rd_data_s[2:0]      = cmd_r;
            end
            ADR_FSMR: rd_data_s = {4'(tx_count_s), 2'b00, state_r};
            default:  rd_data_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Bus acknowledge and read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r <= 1'b0;
            dat_r <= {DATA_WIDTH{1'b0}};
        end else begin
            ack_r <= req_s;
            dat_r <= rd_s ? rd_data_s : {DATA_WIDTH{1'b0}};
        end
    end

    // CSR fields and sticky overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_r  <= 1'b0;
            ie_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (csr_wr_s) begin
            en_r  <= dat_i[CSR_EN];
            ie_r  <= dat_i[CSR_IE];
            ovf_r <= 1'b0;
        end else if (tx_drop_s) begin
            ovf_r <= 1'b1;
        end
    end

    // Receive byte register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_r <= {DATA_WIDTH{1'b0}};
        end else if (rx_wr_i) begin
            rx_r <= rx_data_i;
        end
    end

    // Command code and completion flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_r <= 3'd0;
            don_r <= 1'b0;
            nak_r <= 1'b0;
            arl_r <= 1'b0;
            err_r <= 1'b0;
        end else if (cmd_accept_s) begin
            cmd_r <= dat_i[2:0];
            don_r <= 1'b0;
            nak_r <= 1'b0;
            arl_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (cmd_reject_s) begin
                err_r <= 1'b1;
            end
            if (done_ev_s) begin
                don_r <= 1'b1;
                nak_r <= status_i[1];
                arl_r <= status_i[0];
            end else if (abort_s || timeout_s) begin
                err_r <= 1'b1;
                if (timeout_s) begin
                    don_r <= 1'b0;
                end
            end
        end
    end

    // Level interrupt; a new set beats a simultaneous CMDR read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_r <= 1'b1;
        end else if (cmdr_rd_s) begin
            irq_r <= 1'b0;
        end
    end

    assign ack_o       = ack_r;
    assign dat_o       = dat_r;
    assign irq_o       = irq_r;
    assign cmd_valid_o = cmd_valid_r;
    assign cmd_o       = cmd_r;

endmodule
